// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares one boot SPI flash between the DSP and CPU masters.
// Define SPI_FLASH_ARB_RR_EN for round-robin tie-break; default is DSP priority.
module spi_flash_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic [15:0] MAX_HOLD     = 16'd50000
) (
  input  logic sysclk,
  input  logic reset_INV,
  input  logic dsp_req,
  input  logic cpu_req,
  output logic dsp_gnt,
  output logic cpu_gnt,
  input  logic dsp_spi_clk,
  input  logic dsp_spi_mosi,
  input  logic dsp_spi_cs_INV,
  output logic dsp_spi_miso,
  input  logic cpu_spi_clk,
  input  logic cpu_spi_mosi,
  input  logic cpu_spi_cs_INV,
  output logic cpu_spi_miso,
  output logic flash_clk,
  output logic flash_mosi,
  output logic flash_cs_INV,
  input  logic flash_miso,
  output logic hold_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    OWN_DSP,
    OWN_CPU,
    GUARD
  } state_e;

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

  logic [1:0] dsp_req_q;
  logic [1:0] cpu_req_q;
  logic [1:0] dsp_cs_q;
  logic [1:0] cpu_cs_q;

  state_e      state_q, state_d;
  logic [3:0]  guard_q, guard_d;
  logic [15:0] hold_q, hold_d;
  logic        timeout_q, timeout_d;
  logic        dsp_gnt_q, cpu_gnt_q;

  logic dsp_req_s, cpu_req_s;
  logic dsp_cs_s, cpu_cs_s;
  logic own_dsp, own_req, oth_req, own_cs;
  logic hold_exp, dsp_win;

  assign dsp_req_s = dsp_req_q[1];
  assign cpu_req_s = cpu_req_q[1];
  assign dsp_cs_s  = dsp_cs_q[1];
  assign cpu_cs_s  = cpu_cs_q[1];

  // Two-stage synchronizers for the asynchronous request and chip-select levels
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      dsp_req_q <= 2'b00;
      cpu_req_q <= 2'b00;
      dsp_cs_q  <= 2'b11;
      cpu_cs_q  <= 2'b11;
    end else begin
      dsp_req_q <= {dsp_req_q[0], dsp_req};
      cpu_req_q <= {cpu_req_q[0], cpu_req};
      dsp_cs_q  <= {dsp_cs_q[0], dsp_spi_cs_INV};
      cpu_cs_q  <= {cpu_cs_q[0], cpu_spi_cs_INV};
    end
  end

`ifdef SPI_FLASH_ARB_RR_EN
  logic last_cpu_q;

  // Remember who owned last so a tie goes to the other side
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      last_cpu_q <= 1'b1;
    end else if (state_q == IDLE && state_d != IDLE) begin
      last_cpu_q <= (state_d == OWN_CPU);
    end
  end

  assign dsp_win = dsp_req_s && (!cpu_req_s || last_cpu_q);
`else
  assign dsp_win = dsp_req_s;
`endif

  assign own_dsp  = (state_q == OWN_DSP);
  assign own_req  = own_dsp ? dsp_req_s : cpu_req_s;
  assign oth_req  = own_dsp ? cpu_req_s : dsp_req_s;
  assign own_cs   = own_dsp ? dsp_cs_s : cpu_cs_s;
  assign hold_exp = (MAX_HOLD != 16'd0) && (hold_q >= MAX_HOLD);

  // State, grant, counter and timeout-pulse registers
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_q   <= IDLE;
      guard_q   <= 4'd0;
      hold_q    <= 16'd0;
      timeout_q <= 1'b0;
      dsp_gnt_q <= 1'b0;
      cpu_gnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      dsp_gnt_q <= (state_d == OWN_DSP);
      cpu_gnt_q <= (state_d == OWN_CPU);
    end
  end

  // Ownership only changes while the owner's CS is high
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dsp_req_s || cpu_req_s) begin
          state_d = dsp_win ? OWN_DSP : OWN_CPU;
          hold_d  = 16'd0;
        end
      end
      OWN_DSP, OWN_CPU: begin
        if (hold_q != 16'hFFFF) begin
          hold_d = hold_q + 16'd1;
        end
        if (own_cs) begin
          if (!own_req) begin
            state_d = GUARD;
            guard_d = GUARD_LOAD;
          end else if (hold_exp && oth_req) begin
            state_d   = GUARD;
            guard_d   = GUARD_LOAD;
            timeout_d = 1'b1;
          end
        end
      end
      GUARD: begin
        if (guard_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dsp_gnt      = dsp_gnt_q;
  assign cpu_gnt      = cpu_gnt_q;
  assign hold_timeout = timeout_q;

  assign flash_clk  = (dsp_gnt_q & dsp_spi_clk)
                    | (cpu_gnt_q & cpu_spi_clk);
  assign flash_mosi = (dsp_gnt_q & dsp_spi_mosi)
                    | (cpu_gnt_q & cpu_spi_mosi);
  assign flash_cs_INV = dsp_gnt_q ? dsp_spi_cs_INV :
                        cpu_gnt_q ? cpu_spi_cs_INV : 1'b1;

  assign dsp_spi_miso = dsp_gnt_q & flash_miso;
  assign cpu_spi_miso = cpu_gnt_q & flash_miso;

endmodule
